// File: rtl/ptmch_cnt_win.sv
// Measurement-window controller: gates the trigger-pulse counters for a programmed
// number of cycles and publishes per-channel counter deltas over Avalon-MM.
module ptmch_cnt_win #(
    parameter int SETTLE_CYC = 8,
    parameter int CNT_W      = 32
) (
    input  logic             CLK100M,
    input  logic             RESET,
    input  logic [3:0]       AVS_ADDRESS,
    input  logic             AVS_READ,
    input  logic             AVS_WRITE,
    input  logic [31:0]      AVS_WRITEDATA,
    output logic [31:0]      AVS_READDATA,
    output logic             AVS_READDATAVALID,
    input  logic [CNT_W-1:0] CNT_PRGEXCT,
    input  logic [CNT_W-1:0] CNT_RDSTAT,
    input  logic [CNT_W-1:0] CNT_BLKERS,
    input  logic [CNT_W-1:0] CNT_PDREAD,
    input  logic [CNT_W-1:0] CNT_WRSTAT,
    output logic [4:0]       TRG_GATE,
    output logic             IRQ
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_SETTLE  = 2'd2;
    localparam logic [1:0] ST_CAPTURE = 2'd3;

    logic [1:0]       state;
    logic [31:0]      down_cnt;
    logic [7:0]       settle_cnt;
    logic [31:0]      elapsed;
    logic [4:0]       active_mask;
    logic [4:0]       sat;
    logic [CNT_W-1:0] snap_start [5];
    logic [CNT_W-1:0] delta      [5];
    logic [CNT_W-1:0] cnt_now    [5];

    logic        irq_en;
    logic [4:0]  ch_mask;
    logic [31:0] winlen;
    logic        done;
    logic        aborted;
    logic        err;

    logic        wr_ctrl;
    logic        wr_status;
    logic        start_req;
    logic        abort_req;
    logic        start_valid;
    logic [31:0] rd_mux;

    assign cnt_now[0] = CNT_PRGEXCT;
    assign cnt_now[1] = CNT_RDSTAT;
    assign cnt_now[2] = CNT_BLKERS;
    assign cnt_now[3] = CNT_PDREAD;
    assign cnt_now[4] = CNT_WRSTAT;

    // ABORT in the same write as START takes precedence and suppresses it
    assign wr_ctrl     = AVS_WRITE && (AVS_ADDRESS == 4'd0);
    assign wr_status   = AVS_WRITE && (AVS_ADDRESS == 4'd2);
    assign abort_req   = wr_ctrl && AVS_WRITEDATA[1];
    assign start_req   = wr_ctrl && AVS_WRITEDATA[0] && !AVS_WRITEDATA[1];
    assign start_valid = (winlen != 32'd0) && (AVS_WRITEDATA[8:4] != 5'd0);

    assign TRG_GATE = (state == ST_RUN) ? active_mask : 5'd0;

    always_ff @(posedge CLK100M or posedge RESET) begin
        if (RESET) begin
            state       <= ST_IDLE;
            down_cnt    <= '0;
            settle_cnt  <= '0;
            elapsed     <= '0;
            active_mask <= '0;
            sat         <= '0;
            for (int i = 0; i < 5; i++) begin
                snap_start[i] <= '0;
                delta[i]      <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_req && start_valid) begin
                        for (int i = 0; i < 5; i++) snap_start[i] <= cnt_now[i];
                        down_cnt    <= winlen;
                        elapsed     <= '0;
                        sat         <= '0;
                        active_mask <= AVS_WRITEDATA[8:4];
                        state       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    elapsed <= elapsed + 32'd1;
                    if (abort_req) begin
                        state <= ST_IDLE;
                    end else begin
                        down_cnt <= down_cnt - 32'd1;
                        if (down_cnt == 32'd1) begin
                            settle_cnt <= '0;
                            state      <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (abort_req) begin
                        state <= ST_IDLE;
                    end else if (settle_cnt == 8'(SETTLE_CYC - 1)) begin
                        state <= ST_CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                ST_CAPTURE: begin
                    // Delta is modular so a counter wrapping inside the window still measures correctly
                    for (int i = 0; i < 5; i++) begin
                        if (active_mask[i]) begin
                            delta[i] <= cnt_now[i] - snap_start[i];
                            sat[i]   <= &cnt_now[i];
                        end else begin
                            delta[i] <= '0;
                            sat[i]   <= 1'b0;
                        end
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK100M or posedge RESET) begin
        if (RESET) begin
            irq_en  <= 1'b0;
            ch_mask <= '0;
            winlen  <= '0;
            done    <= 1'b0;
            aborted <= 1'b0;
            err     <= 1'b0;
            IRQ     <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                irq_en  <= AVS_WRITEDATA[2];
                ch_mask <= AVS_WRITEDATA[8:4];
            end
            if (AVS_WRITE && (AVS_ADDRESS == 4'd1)) winlen <= AVS_WRITEDATA;
            if (wr_status) begin
                if (AVS_WRITEDATA[1]) done    <= 1'b0;
                if (AVS_WRITEDATA[2]) aborted <= 1'b0;
                if (AVS_WRITEDATA[3]) err     <= 1'b0;
            end
            // Set events are placed after the clears so they win a same-cycle W1C
            if (state == ST_CAPTURE) done <= 1'b1;
            if (abort_req && ((state == ST_RUN) || (state == ST_SETTLE))) aborted <= 1'b1;
            if (start_req && (state == ST_IDLE) && !start_valid) err <= 1'b1;
            IRQ <= done & irq_en;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (AVS_ADDRESS)
            4'd0: rd_mux = {23'd0, ch_mask, 1'b0, irq_en, 2'b00};
            4'd1: rd_mux = winlen;
            4'd2: rd_mux = {19'd0, sat, 4'd0, err, aborted, done, (state != ST_IDLE)};
            4'd3: rd_mux = elapsed;
            4'd4: rd_mux[CNT_W-1:0] = delta[0];
            4'd5: rd_mux[CNT_W-1:0] = delta[1];
            4'd6: rd_mux[CNT_W-1:0] = delta[2];
            4'd7: rd_mux[CNT_W-1:0] = delta[3];
            4'd8: rd_mux[CNT_W-1:0] = delta[4];
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge CLK100M or posedge RESET) begin
        if (RESET) begin
            AVS_READDATA      <= '0;
            AVS_READDATAVALID <= 1'b0;
        end else begin
            AVS_READDATA      <= AVS_READ ? rd_mux : 32'd0;
            AVS_READDATAVALID <= AVS_READ;
        end
    end

endmodule
